// File: rtl/fifo_flex_pkg.sv
// Shared constants and helpers for the fifo_flex FIFO and its pointer sub-module.
package fifo_flex_pkg;

    localparam int FIFO_DEF_DATA_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH      = 7;

    // Occupancy needs to represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_flex_ptr.sv
// Wrapping pointer for fifo_flex: advances on inc and wraps explicitly from DEPTH-1 to 0.
module fifo_flex_ptr #(
    parameter  int DEPTH = 7,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Explicit wrap keeps non-power-of-2 depths correct.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with arbitrary depth, exact count, almost flags and standard/FWFT read.
// Optional sticky overflow/underflow flags are built when FIFO_FLEX_ERR_FLAGS_EN is defined.
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter  int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter  int DEPTH      = FIFO_DEF_DEPTH,
    parameter  int AF_THRESH  = DEPTH - 1,
    parameter  int AE_THRESH  = 1,
    parameter  int FWFT       = 0,
    localparam int CW         = count_width(DEPTH),
    localparam int PW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
`ifdef FIFO_FLEX_ERR_FLAGS_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         w_ptr;
    logic [PW-1:0]         r_ptr;
    logic [CW-1:0]         count_reg;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_acc = w_en & ~full;
    assign rd_acc = r_en & ~empty;

    // Flags decode the registered count only, so they lag the accepting edge by one cycle.
    assign full         = (count_reg == CW'(DEPTH));
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= CW'(AF_THRESH));
    assign almost_empty = (count_reg <= CW'(AE_THRESH));
    assign count        = count_reg;

    fifo_flex_ptr #(.DEPTH(DEPTH)) u_w_ptr (.clk(clk), .rst(rst), .inc(wr_acc), .ptr(w_ptr));
    fifo_flex_ptr #(.DEPTH(DEPTH)) u_r_ptr (.clk(clk), .rst(rst), .inc(rd_acc), .ptr(r_ptr));

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[w_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (wr_acc != rd_acc) begin
            count_reg <= wr_acc ? count_reg + CW'(1) : count_reg - CW'(1);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; r_en only pops it.
            assign data_out = mem[r_ptr];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_out_reg;
            logic                  rd_valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_out_reg <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_acc;
                    if (rd_acc) begin
                        data_out_reg <= mem[r_ptr];
                    end
                end
            end

            assign data_out = data_out_reg;
            assign rd_valid = rd_valid_reg;
        end
    endgenerate

`ifdef FIFO_FLEX_ERR_FLAGS_EN
    // Sticky error flags; a new error event beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en & full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (r_en & empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: standard-mode and FWFT instances with a scoreboard queue.
// Error-flag checks are included when FIFO_FLEX_ERR_FLAGS_EN is defined.
module tb_fifo_flex;
    import fifo_flex_pkg::*;

    localparam int DW = 8;
    localparam int D  = 7;
    localparam int CW = count_width(D);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          s_w_en, s_r_en, s_valid, s_full, s_empty, s_af, s_ae;
    logic [DW-1:0] s_din, s_dout;
    logic [CW-1:0] s_count;
    logic          f_w_en, f_r_en, f_valid, f_full, f_empty, f_af, f_ae;
    logic [DW-1:0] f_din, f_dout;
    logic [CW-1:0] f_count;
`ifdef FIFO_FLEX_ERR_FLAGS_EN
    logic s_err_clr, s_ovf, s_unf, f_err_clr, f_ovf, f_unf;
`endif

    fifo_flex #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .w_en(s_w_en), .data_in(s_din), .r_en(s_r_en),
`ifdef FIFO_FLEX_ERR_FLAGS_EN
        .err_clr(s_err_clr), .overflow(s_ovf), .underflow(s_unf),
`endif
        .data_out(s_dout), .rd_valid(s_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count)
    );

    fifo_flex #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(f_w_en), .data_in(f_din), .r_en(f_r_en),
`ifdef FIFO_FLEX_ERR_FLAGS_EN
        .err_clr(f_err_clr), .overflow(f_ovf), .underflow(f_unf),
`endif
        .data_out(f_dout), .rd_valid(f_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            m_count  = 0;
    logic [DW-1:0] exp_q[$];
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data  = '0;
    logic [DW-1:0] f_q[$];

    // One clock of standard-instance stimulus; the model predicts acceptance from its own count.
    task automatic tick(input logic w, input logic [DW-1:0] d, input logic r);
        bit wa, ra;
        wa = w && (m_count < D);
        ra = r && (m_count > 0);
        s_w_en = w; s_din = d; s_r_en = r;
        @(posedge clk); #1;
        s_w_en = 1'b0; s_r_en = 1'b0;
        if (ra) exp_data = exp_q.pop_front();
        if (wa) exp_q.push_back(d);
        exp_valid = ra;
        m_count = m_count + int'(wa) - int'(ra);
        $display("txn w=%0b d=%02h r=%0b -> count=%0d valid=%0b dout=%02h", w, d, r, s_count, s_valid, s_dout);
    endtask

    task automatic model_reset();
        m_count = 0; exp_q.delete(); exp_valid = 1'b0; exp_data = '0; f_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_w_en = 0; s_r_en = 0; s_din = '0; f_w_en = 0; f_r_en = 0; f_din = '0;
`ifdef FIFO_FLEX_ERR_FLAGS_EN
        s_err_clr = 0; f_err_clr = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++; if (s_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", s_count); end
        n_checks++; if ({s_empty, s_full, s_ae, s_af} !== 4'b1010) begin n_fail++; $display("FAIL reset_flags: got e/f/ae/af=%b expected 1010", {s_empty, s_full, s_ae, s_af}); end
        n_checks++; if ({s_valid, s_dout} !== '0) begin n_fail++; $display("FAIL reset_out: got valid=%0b dout=%02h expected 0/00", s_valid, s_dout); end
        n_checks++; if ({f_valid, f_empty, f_count} !== {2'b01, CW'(0)}) begin n_fail++; $display("FAIL reset_fwft: got valid=%0b empty=%0b count=%0d expected 0/1/0", f_valid, f_empty, f_count); end
`ifdef FIFO_FLEX_ERR_FLAGS_EN
        n_checks++; if ({s_ovf, s_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", {s_ovf, s_unf}); end
`endif
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) begin
            tick(1'b1, DW'(i), 1'b0);
            n_checks++; if (s_count !== CW'(i)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", s_count, i); end
            n_checks++; if (s_af !== (i >= D - 1)) begin n_fail++; $display("FAIL fill_af: got %0b at count %0d", s_af, i); end
            n_checks++; if (s_full !== (i == D)) begin n_fail++; $display("FAIL fill_full: got %0b at count %0d", s_full, i); end
        end
        tick(1'b1, 8'hFF, 1'b0);
        n_checks++; if (s_count !== CW'(D) || s_full !== 1'b1) begin n_fail++; $display("FAIL fill_drop: got count=%0d full=%0b expected 7/1", s_count, s_full); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= D; i++) begin
            tick(1'b0, '0, 1'b1);
            n_checks++; if (s_dout !== exp_data || exp_data !== DW'(i)) begin n_fail++; $display("FAIL drain_data: got %02h expected %02h", s_dout, DW'(i)); end
            n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid: got %0b expected 1", s_valid); end
            n_checks++; if (s_count !== CW'(m_count) || s_ae !== (m_count <= 1) || s_empty !== (m_count == 0)) begin
                n_fail++; $display("FAIL drain_flags: got count=%0d ae=%0b empty=%0b expected count %0d", s_count, s_ae, s_empty, m_count);
            end
        end
        tick(1'b0, '0, 1'b1);
        n_checks++; if (s_valid !== 1'b0 || s_dout !== 8'h07 || s_count !== '0) begin
            n_fail++; $display("FAIL drain_underrun: got valid=%0b dout=%02h count=%0d expected 0/07/0", s_valid, s_dout, s_count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, DW'(8'h10 + i), 1'b0);
            n_checks++; if (s_count !== CW'(1) || s_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_write: got count=%0d valid=%0b expected 1/0", s_count, s_valid); end
            tick(1'b0, '0, 1'b1);
            n_checks++; if (s_dout !== exp_data || s_valid !== 1'b1 || s_count !== '0) begin
                n_fail++; $display("FAIL wrap_read: got dout=%02h valid=%0b count=%0d expected %02h/1/0", s_dout, s_valid, s_count, exp_data);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) tick(1'b1, DW'(8'h30 + i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, DW'(8'h40 + i), 1'b1);
            n_checks++; if (s_count !== CW'(3) || s_valid !== 1'b1 || s_dout !== exp_data) begin
                n_fail++; $display("FAIL simul_mid: got count=%0d valid=%0b dout=%02h expected 3/1/%02h", s_count, s_valid, s_dout, exp_data);
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b1, DW'(8'h50 + i), 1'b0);
        tick(1'b1, 8'hEE, 1'b1);
        n_checks++; if (s_count !== CW'(6) || s_dout !== exp_data) begin n_fail++; $display("FAIL simul_full: got count=%0d dout=%02h expected 6/%02h", s_count, s_dout, exp_data); end
        while (m_count > 0) begin
            tick(1'b0, '0, 1'b1);
            n_checks++; if (s_dout !== exp_data || s_valid !== 1'b1) begin n_fail++; $display("FAIL simul_order: got %02h expected %02h", s_dout, exp_data); end
        end
        tick(1'b1, 8'h5A, 1'b1);
        n_checks++; if (s_count !== CW'(1) || s_valid !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got count=%0d valid=%0b expected 1/0", s_count, s_valid); end
        tick(1'b0, '0, 1'b1);
        n_checks++; if (s_dout !== 8'h5A || s_empty !== 1'b1) begin n_fail++; $display("FAIL simul_last: got dout=%02h empty=%0b expected 5A/1", s_dout, s_empty); end
    endtask

    task automatic test_fwft();
        logic [DW-1:0] head;
        f_w_en = 1'b1; f_din = 8'hA5; f_q.push_back(8'hA5);
        @(posedge clk); #1; f_w_en = 1'b0;
        $display("txn fwft write A5 -> dout=%02h valid=%0b", f_dout, f_valid);
        head = f_q[0];
        n_checks++; if (f_dout !== head || f_valid !== 1'b1 || f_empty !== 1'b0) begin
            n_fail++; $display("FAIL fwft_show: got dout=%02h valid=%0b empty=%0b expected %02h/1/0", f_dout, f_valid, f_empty, head);
        end
        f_w_en = 1'b1; f_din = 8'hB6; f_q.push_back(8'hB6);
        @(posedge clk); #1; f_w_en = 1'b0;
        n_checks++; if (f_dout !== f_q[0] || f_count !== CW'(2)) begin n_fail++; $display("FAIL fwft_hold: got dout=%02h count=%0d expected %02h/2", f_dout, f_count, f_q[0]); end
        for (int i = 0; i < 2; i++) begin
            f_r_en = 1'b1; void'(f_q.pop_front());
            @(posedge clk); #1; f_r_en = 1'b0;
            $display("txn fwft pop -> dout=%02h valid=%0b empty=%0b", f_dout, f_valid, f_empty);
            if (f_q.size() > 0) begin
                head = f_q[0];
                n_checks++; if (f_dout !== head || f_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_next: got %02h/%0b expected %02h/1", f_dout, f_valid, head); end
            end else begin
                n_checks++; if (f_empty !== 1'b1 || f_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_empty: got empty=%0b valid=%0b expected 1/0", f_empty, f_valid); end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, DW'(8'h60 + i), 1'b0);
        n_checks++; if (s_count !== CW'(4)) begin n_fail++; $display("FAIL areset_pre: got %0d expected 4", s_count); end
        @(negedge clk); rst = 1'b1; #1;
        n_checks++; if (s_count !== '0 || s_empty !== 1'b1 || s_dout !== '0) begin
            n_fail++; $display("FAIL areset_now: got count=%0d empty=%0b dout=%02h expected 0/1/00", s_count, s_empty, s_dout);
        end
        #1 rst = 1'b0;
        model_reset();
        tick(1'b0, '0, 1'b1);
        n_checks++; if (s_valid !== 1'b0 || s_count !== '0) begin n_fail++; $display("FAIL areset_after: got valid=%0b count=%0d expected 0/0", s_valid, s_count); end
    endtask

`ifdef FIFO_FLEX_ERR_FLAGS_EN
    task automatic test_err_flags();
        for (int i = 0; i < D; i++) tick(1'b1, DW'(i), 1'b0);
        n_checks++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL err_ovf_early: got %0b expected 0", s_ovf); end
        tick(1'b1, 8'hAA, 1'b0);
        n_checks++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL err_ovf_set: got %0b expected 1", s_ovf); end
        tick(1'b0, '0, 1'b0);
        n_checks++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL err_ovf_sticky: got %0b expected 1", s_ovf); end
        s_err_clr = 1'b1; tick(1'b1, 8'hAB, 1'b0);
        n_checks++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %0b expected 1", s_ovf); end
        tick(1'b0, '0, 1'b0); s_err_clr = 1'b0;
        n_checks++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL err_ovf_clr: got %0b expected 0", s_ovf); end
        while (m_count > 0) tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        n_checks++; if (s_unf !== 1'b1 || s_ovf !== 1'b0) begin n_fail++; $display("FAIL err_unf_set: got unf=%0b ovf=%0b expected 1/0", s_unf, s_ovf); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_async_reset();
`ifdef FIFO_FLEX_ERR_FLAGS_EN
        test_err_flags();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised synchronous single-clock FIFO, next generation of the team's basic FIFO. Supports arbitrary, including non-power-of-2, depth and an exact occupancy count. Adds programmable almost-full/almost-empty thresholds and a selectable standard or first-word-fall-through (FWFT) read mode. Used as the general buffering primitive between datapath stages.

Parameters:
DATA_WIDTH, 8, width of each stored word.
DEPTH, 7, number of entries; any value >= 2.
AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset, asynchronous, active-high.
w_en  input  1  write request.
data_in  input  DATA_WIDTH  write data.
r_en  input  1  read request (standard mode) or pop (FWFT mode).
data_out  output  DATA_WIDTH  read data.
rd_valid  output  1  data_out holds a newly read word.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
count  output  CW  occupancy, where CW = $clog2(DEPTH+1).

Behaviour:
- Reset: one clock; reset is asynchronous and active-high, on port rst. It clears w_ptr, r_ptr, count, data_out and rd_valid to 0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0. Storage array is not reset.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- wr_acc = w_en & ~full; rd_acc = r_en & ~empty. Requests that are not accepted are dropped and leave no state change.
- Write: on wr_acc, mem[w_ptr] <= data_in and w_ptr advances.
- Pointers: width $clog2(DEPTH); each wraps explicitly from DEPTH-1 to 0, with no reliance on natural binary overflow.
- count next = count + wr_acc - rd_acc:
  - both accepted in the same cycle: count unchanged;
  - full with both w_en and r_en: only the read is accepted (write dropped) and count decrements;
  - empty with both: only the write is accepted and count increments.
- Flags are combinational decodes of the count register only, so they update the cycle after the accepting edge.
- Standard mode (FWFT=0):
  - on rd_acc, data_out <= mem[r_ptr] and r_ptr advances;
  - rd_valid is a 1-cycle pulse in the cycle after rd_acc;
  - read latency is 1 cycle;
  - data_out holds its last value when no read is accepted.
- FWFT mode (FWFT=1):
  - data_out = mem[r_ptr] combinationally, valid whenever empty=0;
  - rd_valid = ~empty;
  - r_en pops the head word at the edge;
  - a word written into an empty FIFO appears on data_out the cycle after the write.
- Throughput: one write plus one read per cycle is sustained at any occupancy other than the full/empty corner cases above.

Optional Feature:
Macro FIFO_FLEX_ERR_FLAGS_EN.
- Defined, the block adds:
  - input err_clr (1 bit);
  - output overflow (1 bit): sticky; set at the edge where w_en & full;
  - output underflow (1 bit): sticky; set at the edge where r_en & empty.
- Both flags are cleared by rst or by err_clr. When err_clr coincides with a new error event, set wins.
- Not defined: these ports and their logic are absent. Dropped requests are silent; the rest of the behaviour is identical.

Decomposition:
- Package fifo_flex_pkg holds:
  - default constants FIFO_DEF_DATA_WIDTH=8 and FIFO_DEF_DEPTH=7;
  - a function returning the count width, $clog2(depth+1).
- One sub-module, fifo_flex_ptr: parameter DEPTH, with inputs clk, rst and inc, and output ptr. It is a wrapping pointer counter instantiated twice, once for the write pointer and once for the read pointer.

Test Plan:
- Reset and fill, DEPTH=7, FWFT=0: assert rst, then write 0x01..0x07 -> count steps 1..7; almost_full at count 6; full at 7; an 8th write (0xFF) is dropped and count stays 7.
- Drain in order: after the fill, pulse r_en 7 times -> data_out = 0x01..0x07, each with a 1-cycle rd_valid pulse; empty=1; almost_empty at count 1; a further r_en changes neither data_out nor count.
- Wrap-around: run 20 interleaved single write/read pairs with data 0x10..0x23 -> read order matches write order across the 6->0 pointer wrap; count never exceeds 1.
- Simultaneous access: at count 3, hold w_en and r_en for 4 cycles -> count stays 3 and output order is preserved; when full with both asserted, count goes 7->6 with the write dropped; when empty with both asserted, count goes 0->1 with the read ignored.
- FWFT=1: write 0xA5 into the empty FIFO -> the next cycle shows data_out=0xA5 and rd_valid=1 with no r_en; then r_en -> empty=1 the following cycle.
- Async reset mid-stream plus error flags (macro defined): at count 4, assert rst between edges -> count=0 and empty=1 immediately; write while full -> overflow=1 stays set until err_clr.
